// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Decode-side pipeline controller. Generates the IF/ID and ID/EX register
//   controls for load-use bubbles, taken-branch flushes and data-memory freezes.
//   It also keeps saturating performance counters for stall, flush and freeze
//   cycles.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   id_rs, id_rt               source register fields of the instruction in ID
//   id_uses_rs, id_uses_rt     ID instruction actually reads rs / rt
//   id_ex_mem_read, id_ex_rd   load flag and destination currently in ID/EX
//   branch_taken               branch resolved taken this cycle (EX/MEM)
//   mem_busy                   data memory not ready
//   pc_write, if_id_write      PC / IF/ID load enables
//   if_id_flush, id_ex_flush   load NOP / all-zero controls
//   id_ex_bubble               zero ID/EX controls and set its stall flag
//   pipe_freeze                hold every pipeline register
//   stall_cnt, flush_cnt, freeze_cnt  saturating event counters
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned LU_STALL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic [0:0] {StRun, StLuStall} state_e;

    localparam logic [1:0]       LuInit = 2'(LU_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic [1:0]       lu_left_q, lu_left_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;
    logic             hz, stall;
    logic             stall_inc, flush_inc, freeze_inc;

    assign hz = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                ((id_uses_rs && (id_rs == id_ex_rd)) || (id_uses_rt && (id_rt == id_ex_rd)));

    // hz is ignored in LU_STALL: ID/EX already holds a bubble.
    assign stall = (state_q == StLuStall) || hz;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_flush  = 1'b0;
        pipe_freeze  = 1'b0;
        state_d      = state_q;
        lu_left_d    = lu_left_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        freeze_inc   = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mem_busy) begin
            // Everything holds, including a pending branch, until memory is ready.
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            freeze_inc  = 1'b1;
        end else if (branch_taken) begin
            // IF/ID stays write-enabled so it can capture the NOP.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = StRun;
            lu_left_d   = 2'd0;
            flush_inc   = 1'b1;
        end else if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            if (state_q == StRun) begin
                if (LU_STALL_CYCLES == 1) begin
                    state_d   = StRun;
                    lu_left_d = 2'd0;
                end else begin
                    state_d   = StLuStall;
                    lu_left_d = LuInit;
                end
            end else begin
                lu_left_d = lu_left_q - 2'd1;
                if (lu_left_q == 2'd1) begin
                    state_d = StRun;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StRun;
            lu_left_q    <= 2'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lu_left_q <= lu_left_d;
            if (stall_inc && (stall_cnt_q != CntMax)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != CntMax)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
            if (freeze_inc && (freeze_cnt_q != CntMax)) begin
                freeze_cnt_q <= freeze_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Drives three controller instances (LU_STALL_CYCLES 1/3/2, CNT_W 16/16/4)
//   from one shared stimulus stream: directed scenarios followed by random
//   traffic. Each instance is compared against a countdown-style reference model.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, id_ex_rd;
    logic       id_uses_rs, id_uses_rt, id_ex_mem_read, branch_taken, mem_busy;

    logic [5:0]  ctrl [3];
    logic [15:0] sc0, fc0, zc0, sc1, fc1, zc1;
    logic [3:0]  sc2, fc2, zc2;

    int vectors = 0;
    int errors  = 0;

    // Reference model state: number of forced bubbles still owed after this cycle.
    int pend [3];
    int scnt [3];
    int fcnt [3];
    int zcnt [3];
    int lu_cfg [3] = '{1, 3, 2};
    int cw_cfg [3] = '{16, 16, 4};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(16), .LU_STALL_CYCLES(1)) u_dut0 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_write(ctrl[0][5]),
        .if_id_write(ctrl[0][4]), .if_id_flush(ctrl[0][3]), .id_ex_bubble(ctrl[0][2]),
        .id_ex_flush(ctrl[0][1]), .pipe_freeze(ctrl[0][0]), .stall_cnt(sc0),
        .flush_cnt(fc0), .freeze_cnt(zc0)
    );

    pipeline_hazard_ctrl #(.CNT_W(16), .LU_STALL_CYCLES(3)) u_dut1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_write(ctrl[1][5]),
        .if_id_write(ctrl[1][4]), .if_id_flush(ctrl[1][3]), .id_ex_bubble(ctrl[1][2]),
        .id_ex_flush(ctrl[1][1]), .pipe_freeze(ctrl[1][0]), .stall_cnt(sc1),
        .flush_cnt(fc1), .freeze_cnt(zc1)
    );

    pipeline_hazard_ctrl #(.CNT_W(4), .LU_STALL_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_write(ctrl[2][5]),
        .if_id_write(ctrl[2][4]), .if_id_flush(ctrl[2][3]), .id_ex_bubble(ctrl[2][2]),
        .id_ex_flush(ctrl[2][1]), .pipe_freeze(ctrl[2][0]), .stall_cnt(sc2),
        .flush_cnt(fc2), .freeze_cnt(zc2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int w);
        return (v < (1 << w) - 1) ? v + 1 : v;
    endfunction

    // Apply one cycle of inputs, check all instances mid-cycle, then advance the model.
    task automatic step(input logic rst, input logic busy, input logic br, input logic mr,
                        input logic [4:0] rd, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt);
        logic        hz;
        logic [5:0]  exp_ctrl;
        logic [15:0] obs_s, obs_f, obs_z;
        reset = rst; mem_busy = busy; branch_taken = br; id_ex_mem_read = mr;
        id_ex_rd = rd; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        hz = mr && (rd != 0) && ((urs && rs == rd) || (urt && rt == rd));
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            // {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_flush, pipe_freeze}
            if (rst)                      exp_ctrl = 6'b001010;
            else if (busy)                exp_ctrl = 6'b000001;
            else if (br)                  exp_ctrl = 6'b111010;
            else if (pend[i] > 0 || hz)   exp_ctrl = 6'b000100;
            else                          exp_ctrl = 6'b110000;
            case (i)
                0:       begin obs_s = sc0; obs_f = fc0; obs_z = zc0; end
                1:       begin obs_s = sc1; obs_f = fc1; obs_z = zc1; end
                default: begin obs_s = {12'd0, sc2}; obs_f = {12'd0, fc2}; obs_z = {12'd0, zc2}; end
            endcase
            check_eq($sformatf("ctrl[%0d]", i), {26'd0, ctrl[i]}, {26'd0, exp_ctrl});
            check_eq($sformatf("stall_cnt[%0d]", i), {16'd0, obs_s}, scnt[i]);
            check_eq($sformatf("flush_cnt[%0d]", i), {16'd0, obs_f}, fcnt[i]);
            check_eq($sformatf("freeze_cnt[%0d]", i), {16'd0, obs_z}, zcnt[i]);
            if (rst) begin
                pend[i] = 0; scnt[i] = 0; fcnt[i] = 0; zcnt[i] = 0;
            end else if (busy) begin
                zcnt[i] = sat_inc(zcnt[i], cw_cfg[i]);
            end else if (br) begin
                pend[i] = 0;
                fcnt[i] = sat_inc(fcnt[i], cw_cfg[i]);
            end else if (pend[i] > 0) begin
                pend[i]--;
                scnt[i] = sat_inc(scnt[i], cw_cfg[i]);
            end else if (hz) begin
                pend[i] = lu_cfg[i] - 1;
                scnt[i] = sat_inc(scnt[i], cw_cfg[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic hazard();
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            pend[i] = 0; scnt[i] = 0; fcnt[i] = 0; zcnt[i] = 0;
        end
        reset = 1'b1; mem_busy = 1'b0; branch_taken = 1'b0; id_ex_mem_read = 1'b0;
        id_ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        // First edge settles the registers; checking starts with the second reset cycle.
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        idle(2);

        // Single load-use hazard, then the same pattern with rd = 0 (no hazard).
        hazard();
        idle(4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        idle(1);

        // Hazard through rt, then a branch in the second bubble cycle.
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        idle(3);

        // Freeze with a branch held during a multi-cycle stall; branch honoured afterwards.
        hazard();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        idle(4);
        hazard();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        idle(2);

        // Long hazard run saturates the narrow counters.
        for (int k = 0; k < 20; k++) hazard();
        idle(3);

        // Random traffic over a small register space so hazards are frequent.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
